// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake with a main entry plus one skid entry.
// Control bits travel separately from the payload so bubbles always carry all-zero control.
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Bit 0 means "main valid", bit 1 means "skid valid", so both handshake
  // outputs are plain copies of state register bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic push;
  logic pop;
  logic stall;

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign stall_cnt = stall_cnt_q;

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  assign stall = out_valid & ~out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (pop) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
          end else if (push) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can move the stage.
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
          skid_data_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  // Stall is sampled from the pre-flush state; flush never clears the count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid; a second instance with a 2-bit counter
// shares the inputs to observe stall counter saturation.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [127:0] in_data;
  logic [5:0]   in_ctrl;
  logic         in_ready, out_valid;
  logic [127:0] out_data;
  logic [5:0]   out_ctrl;
  logic [15:0]  stall_cnt;
  logic         in_ready2, out_valid2;
  logic [127:0] out_data2;
  logic [5:0]   out_ctrl2;
  logic [1:0]   stall_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
    .stall_cnt(stall_cnt2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; in_valid = 0; in_data = '0; in_ctrl = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cyc(); cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    out_ready = 1;
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0 || out_ctrl !== 6'h0 || in_ready !== 1'b1 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: got v=%b d=%h c=%h r=%b s=%0d, want v=0 d=0 c=0 r=1 s=0",
               out_valid, out_data, out_ctrl, in_ready, stall_cnt);
    end else $display("reset_values ok");
  endtask

  task automatic test_single();
    out_ready = 1; in_valid = 1; in_data = 128'hA5; in_ctrl = 6'h3F;
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 128'hA5 || out_ctrl !== 6'h3F || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_beat: got v=%b d=%h c=%h r=%b, want v=1 d=a5 c=3f r=1",
               out_valid, out_data, out_ctrl, in_ready);
    end else $display("single_beat ok");
    idle();
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0 || out_ctrl !== 6'h0) begin
      errors++;
      $display("FAIL single_drain: got v=%b d=%h c=%h, want v=0 d=0 c=0", out_valid, out_data, out_ctrl);
    end else $display("single_drain ok");
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = 128'(i); in_ctrl = 6'(i);
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 128'(i) || out_ctrl !== 6'(i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_beat%0d: got v=%b d=%0d c=%0d r=%b, want v=1 d=%0d c=%0d r=1",
                 i, out_valid, out_data, out_ctrl, in_ready, i, i);
      end else $display("stream_beat%0d ok", i);
    end
    idle();
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: got v=%b, want v=0", out_valid);
    end else $display("stream_end ok");
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    in_valid = 1; in_data = 128'd1; in_ctrl = 6'd1;
    cyc();
    in_data = 128'd2; in_ctrl = 6'd2;
    cyc();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 128'd1 || out_ctrl !== 6'd1) begin
      errors++;
      $display("FAIL skid_full: got r=%b v=%b d=%0d c=%0d, want r=0 v=1 d=1 c=1",
               in_ready, out_valid, out_data, out_ctrl);
    end else $display("skid_full ok");
    idle();
    out_ready = 1;
    cyc();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 128'd2 || out_ctrl !== 6'd2) begin
      errors++;
      $display("FAIL skid_second: got r=%b v=%b d=%0d c=%0d, want r=1 v=1 d=2 c=2",
               in_ready, out_valid, out_data, out_ctrl);
    end else $display("skid_second ok");
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 6'd0) begin
      errors++;
      $display("FAIL skid_empty: got v=%b c=%0d, want v=0 c=0", out_valid, out_ctrl);
    end else $display("skid_empty ok");
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_data = 128'd1; in_ctrl = 6'd1;
    cyc();
    in_data = 128'd2; in_ctrl = 6'd2;
    cyc();
    flush = 1; in_data = 128'd3; in_ctrl = 6'd3;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0 || out_ctrl !== 6'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_two: got v=%b d=%h c=%h r=%b, want v=0 d=0 c=0 r=1",
               out_valid, out_data, out_ctrl, in_ready);
    end else $display("flush_two ok");
    idle();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 6'h0) begin
        errors++;
        $display("FAIL flush_after%0d: got v=%b c=%h, want v=0 c=0", i, out_valid, out_ctrl);
      end else $display("flush_after%0d ok", i);
    end
  endtask

  task automatic test_stall_cnt();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_data = 128'h77; in_ctrl = 6'h5;
    cyc();
    idle();
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stall_count: got %0d, want 5", stall_cnt);
    end else $display("stall_count ok");
    checks++;
    if (stall_cnt2 !== 2'd3) begin
      errors++;
      $display("FAIL stall_saturate: got %0d, want 3", stall_cnt2);
    end else $display("stall_saturate ok");
    // Flush while downstream is ready: no stall that cycle, count must hold.
    out_ready = 1; flush = 1;
    cyc();
    flush = 0;
    cyc();
    checks++;
    if (stall_cnt !== 16'd5 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_after_flush: got s=%0d v=%b, want s=5 v=0", stall_cnt, out_valid);
    end else $display("stall_after_flush ok");
    do_reset();
    checks++;
    if (stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL stall_reset: got s=%0d s2=%0d, want 0 0", stall_cnt, stall_cnt2);
    end else $display("stall_reset ok");
  endtask

  task automatic test_reset_in_two();
    out_ready = 0;
    in_valid = 1; in_data = 128'd9; in_ctrl = 6'd9;
    cyc();
    in_data = 128'd10; in_ctrl = 6'd10;
    cyc();
    reset = 1; flush = 1; in_data = 128'd11; in_ctrl = 6'd11;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0 || out_ctrl !== 6'h0 || in_ready !== 1'b1 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_in_two: got v=%b d=%h c=%h r=%b s=%0d, want v=0 d=0 c=0 r=1 s=0",
               out_valid, out_data, out_ctrl, in_ready, stall_cnt);
    end else $display("reset_in_two ok");
    idle();
    out_ready = 1;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_beat: got v=%b, want v=0", out_valid);
    end else $display("reset_no_beat ok");
  endtask

  initial begin
    idle();
    out_ready = 1;
    reset = 1;
    test_reset();
    test_single();
    test_stream();
    test_back_to_back();
    test_flush();
    test_stall_cnt();
    test_reset_in_two();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
